// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register with stall-buffered redirects, timed flush and optional PC_PERF_CNT_EN redirect counters
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  npcc,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misalign
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] jump_cnt
`endif
);
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] pend_tgt, raw;
  logic        pend_br, live, take_pend, take_live, load, load_br, capture;
  assign pc_plus4 = pc_out + 32'd4;
  always_comb begin
    live      = (npcc == 2'b01 || npcc == 2'b10) && cnt == 3'd0;
    take_pend = redirect_pending && !stall;
    take_live = live && !stall && !redirect_pending;
    load      = take_pend || take_live;
    capture   = live && stall && !redirect_pending;
    raw       = take_pend ? pend_tgt : (npcc == 2'b01 ? br_target : j_target);
    load_br   = take_pend ? pend_br : npcc == 2'b01;
    cnt_nxt   = load ? 3'(FLUSH_CYCLES) : (cnt == 3'd0 ? 3'd0 : cnt - 3'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out           <= RESET_PC;
      cnt              <= 3'd0;
      flush            <= 1'b0;
      misalign         <= 1'b0;
      redirect_pending <= 1'b0;
      pend_tgt         <= 32'd0;
      pend_br          <= 1'b0;
    end else begin
      pc_out   <= load ? (raw & ~32'h3) : (stall ? pc_out : pc_plus4);
      cnt      <= cnt_nxt;
      flush    <= cnt_nxt != 3'd0;
      misalign <= load && raw[1:0] != 2'b00;
      if (capture) begin
        redirect_pending <= 1'b1;
        pend_tgt         <= raw;
        pend_br          <= load_br;
      end else if (take_pend)
        redirect_pending <= 1'b0;
    end
  end
`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_cnt <= 32'd0;
      jump_cnt     <= 32'd0;
    end else begin
      if (load && load_br && ~&br_taken_cnt) br_taken_cnt <= br_taken_cnt + 32'd1;
      if (load && !load_br && ~&jump_cnt) jump_cnt <= jump_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed literal checks plus randomized stimulus against a behavioural model
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int FC = 2;
  logic clk = 0, rst = 1, stall = 0;
  logic [1:0] npcc = 0;
  logic [31:0] br_target = 0, j_target = 0;
  logic [31:0] pc_out, pc_plus4;
  logic flush, redirect_pending, misalign;
`ifdef PC_PERF_CNT_EN
  logic [31:0] br_taken_cnt, jump_cnt;
`endif
  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [31:0] m_pc, m_ptgt, m_bc, m_jc;
  bit m_pend, m_pbr, m_mis;
  int m_fl;

  pc_fetch_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .npcc(npcc),
    .br_target(br_target), .j_target(j_target),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .flush(flush),
    .redirect_pending(redirect_pending), .misalign(misalign)
`ifdef PC_PERF_CNT_EN
    , .br_taken_cnt(br_taken_cnt), .jump_cnt(jump_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one decision per clock straight from the redirect priority rules
  always @(posedge clk) begin
    bit red, isbr, ld, lb;
    logic [31:0] tgt, r;
    if (rst) begin
      m_pc = RPC; m_pend = 0; m_fl = 0; m_mis = 0; m_bc = 0; m_jc = 0;
    end else begin
      red  = (npcc == 2'd1 || npcc == 2'd2) && m_fl == 0;
      isbr = npcc == 2'd1;
      tgt  = isbr ? br_target : j_target;
      ld = 0; lb = 0; r = 0;
      if (m_pend && !stall) begin
        ld = 1; r = m_ptgt; lb = m_pbr; m_pend = 0;
      end else if (red && !stall) begin
        ld = 1; r = tgt; lb = isbr;
      end else if (red && stall && !m_pend) begin
        m_pend = 1; m_ptgt = tgt; m_pbr = isbr;
      end
      if (m_fl > 0) m_fl--;
      if (ld) m_fl = FC;
      m_mis = ld && r[1:0] != 0;
      if (ld) m_pc = {r[31:2], 2'b00};
      else if (!stall) m_pc = m_pc + 4;
      if (ld && lb && m_bc != 32'hFFFF_FFFF) m_bc++;
      if (ld && !lb && m_jc != 32'hFFFF_FFFF) m_jc++;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("flush", {31'd0, flush}, {31'd0, m_fl != 0});
    chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`ifdef PC_PERF_CNT_EN
    chk("br_taken_cnt", br_taken_cnt, m_bc);
    chk("jump_cnt", jump_cnt, m_jc);
`endif
  end

  task automatic step(input bit r, input bit s, input logic [1:0] n, input logic [31:0] b, input logic [31:0] j);
    rst = r; stall = s; npcc = n; br_target = b; j_target = j;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    chk("reset pc", pc_out, 32'h3000);
    chk("reset flush", {31'd0, flush}, 32'd0);
    step(0, 0, 0, 0, 0);              chk("seq1", pc_out, 32'h3004);
    step(0, 0, 0, 0, 0);              chk("seq2", pc_out, 32'h3008);
    step(0, 0, 1, 32'h3100, 0);       chk("branch pc", pc_out, 32'h3100);
    chk("branch flush", {31'd0, flush}, 32'd1);
    step(0, 0, 2, 0, 32'h3500);       chk("ignored jump", pc_out, 32'h3104);
    chk("flush 2nd", {31'd0, flush}, 32'd1);
    step(0, 0, 0, 0, 0);              chk("after flush", pc_out, 32'h3108);
    chk("flush done", {31'd0, flush}, 32'd0);
    step(0, 1, 2, 0, 32'h3200);       chk("stall hold", pc_out, 32'h3108);
    chk("pending set", {31'd0, redirect_pending}, 32'd1);
    step(0, 1, 1, 32'h3300, 0);       chk("stall hold2", pc_out, 32'h3108);
    step(0, 0, 0, 0, 0);              chk("replay", pc_out, 32'h3200);
    chk("pending clr", {31'd0, redirect_pending}, 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);              chk("no 3300", pc_out, 32'h3208);
    step(0, 0, 2, 0, 32'h3203);       chk("misalign pc", pc_out, 32'h3200);
    chk("misalign pulse", {31'd0, misalign}, 32'd1);
    step(0, 0, 0, 0, 0);              chk("misalign end", {31'd0, misalign}, 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 2, 0, 32'hFFFF_FFFC);  chk("top pc", pc_out, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);              chk("wrap", pc_out, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h3400, 0);       chk("pend before rst", {31'd0, redirect_pending}, 32'd1);
    step(1, 1, 0, 0, 0);              chk("rst pc", pc_out, 32'h3000);
    chk("rst pending", {31'd0, redirect_pending}, 32'd0);
    step(0, 0, 0, 0, 0);              chk("no 3400", pc_out, 32'h3004);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b, j;
      b = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      j = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), b, j);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
